// File: rtl/deser_pkg.sv
// deser_pkg -- shared definitions for the deserializer slice.
//   DATA_W   : width of an assembled byte
//   BITCNT_W : width of the bit index within a byte
//   state_t  : framing state (SKIP = discard one dead bit, RUN = assemble)
package deser_pkg;

  localparam int DATA_W   = 8;
  localparam int BITCNT_W = 3;

  typedef enum logic {
    SKIP = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage : deser_pkg

// File: rtl/deser_shift.sv
// deser_shift -- bit-assembly shift register and bit counter.
// Ports:
//   clk         : clock, rising edge
//   reset       : asynchronous active-low reset
//   i_en        : assemble enable (framing FSM is in RUN)
//   i_in        : serial data bit, LSB first
//   i_align     : framing restart; i_in becomes bit 0, counter goes to 1
//   o_bitcnt    : index of the bit that the next edge will store
//   o_byte_done : the current edge samples bit 7 of a byte
//   o_byte      : completed byte {i_in, bits 6..0}, valid with o_byte_done
module deser_shift
  import deser_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                i_en,
  input  logic                i_in,
  input  logic                i_align,
  output logic [BITCNT_W-1:0] o_bitcnt,
  output logic                o_byte_done,
  output logic [DATA_W-1:0]   o_byte
);

  // Only bits 0..6 are stored; bit 7 goes straight from i_in into o_byte.
  logic [DATA_W-2:0]   r_shift;
  logic [BITCNT_W-1:0] r_bitcnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift  <= '0;
      r_bitcnt <= '0;
    end else if (i_align) begin
      // Restart framing: the partial byte is discarded.
      r_shift  <= {{(DATA_W-2){1'b0}}, i_in};
      r_bitcnt <= BITCNT_W'(1);
    end else if (i_en) begin
      for (int i = 0; i < DATA_W-1; i++) begin
        if (r_bitcnt == BITCNT_W'(i)) begin
          r_shift[i] <= i_in;
        end
      end
      // Natural wrap 7 -> 0, no gap cycle between bytes.
      r_bitcnt <= r_bitcnt + BITCNT_W'(1);
    end
  end

  assign o_bitcnt    = r_bitcnt;
  assign o_byte_done = i_en && !i_align && (r_bitcnt == BITCNT_W'(DATA_W-1));
  assign o_byte      = {i_in, r_shift};

endmodule : deser_shift

// File: rtl/deserializer.sv
// deserializer -- serial-to-parallel byte deserializer with a one-byte
// holding register and valid/ready output handshake.
// Ports:
//   clk          : clock, all state on rising edge
//   reset        : asynchronous active-low reset
//   in           : serial data, LSB first, one bit per clk
//   align        : framing restart; the bit on in this cycle is bit 0
//   out          : assembled byte holding register
//   out_valid    : out holds an unconsumed byte
//   out_ready    : consumer accepts out when out_valid && out_ready at an edge
//   overrun      : sticky flag, a completed byte was dropped
//   o_dbg_state  : framing FSM state (debug)
//   o_dbg_bitcnt : next bit index (debug)
// Build option: DESER_OVERRUN_EN enables the sticky overrun flag; without it
// overrun is tied 0 and dropping behaviour is identical.
//
// Handshake: a byte transfers at a rising edge where out_valid && out_ready.
// out_valid rises when a byte completes and may only fall through such a
// transfer; while out_valid=1 and out_ready=0, out is held stable and any
// newly completed byte is dropped.
module deserializer
  import deser_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                in,
  input  logic                align,
  output logic [DATA_W-1:0]   out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                overrun,
  output state_t              o_dbg_state,
  output logic [BITCNT_W-1:0] o_dbg_bitcnt
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_run;
  logic                w_byte_done;
  logic [DATA_W-1:0]   w_byte;
  logic                w_load;
  logic                w_drop;
  logic [DATA_W-1:0]   r_out;
  logic                r_out_valid;

  // SKIP lasts exactly one edge (the serializer's dead cycle); align also
  // lands in RUN and takes priority over the skip.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SKIP:    w_state_nxt = RUN;
      RUN:     w_state_nxt = RUN;
      default: w_state_nxt = SKIP;
    endcase
    if (align) begin
      w_state_nxt = RUN;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= SKIP;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign w_run = (r_state == RUN);

  deser_shift u_shift (
    .clk         (clk),
    .reset       (reset),
    .i_en        (w_run),
    .i_in        (in),
    .i_align     (align),
    .o_bitcnt    (o_dbg_bitcnt),
    .o_byte_done (w_byte_done),
    .o_byte      (w_byte)
  );

  // A completed byte is loaded when the register is empty or being drained
  // at this same edge; otherwise it is dropped.
  assign w_load = w_byte_done && (!r_out_valid || out_ready);
  assign w_drop = w_byte_done && r_out_valid && !out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out       <= w_byte;
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef DESER_OVERRUN_EN
  logic r_overrun;

  // align clears the flag; a drop cannot coincide with align because
  // align suppresses completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overrun <= 1'b0;
    end else if (align) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end
  end

  assign overrun = r_overrun;
`else
  logic w_drop_unused;
  assign w_drop_unused = w_drop;
  assign overrun       = 1'b0;
`endif

  assign out         = r_out;
  assign out_valid   = r_out_valid;
  assign o_dbg_state = r_state;

endmodule : deserializer

// File: tb/tb_deserializer.sv
module tb_deserializer;
  import deser_pkg::*;

  logic                clk;
  logic                reset;
  logic                in;
  logic                align;
  logic [DATA_W-1:0]   out;
  logic                out_valid;
  logic                out_ready;
  logic                overrun;
  state_t              dbg_state;
  logic [BITCNT_W-1:0] dbg_bitcnt;

  int n_checks = 0;
  int n_errors = 0;

`ifdef DESER_OVERRUN_EN
  localparam logic EXP_OVR = 1'b1;
`else
  localparam logic EXP_OVR = 1'b0;
`endif

  deserializer dut (
    .clk          (clk),
    .reset        (reset),
    .in           (in),
    .align        (align),
    .out          (out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .overrun      (overrun),
    .o_dbg_state  (dbg_state),
    .o_dbg_bitcnt (dbg_bitcnt)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: inputs change on the falling edge, outputs sampled #1
  // after the rising edge
  task automatic tick(input logic b, input logic al);
    @(negedge clk);
    in    = b;
    align = al;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] v, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      tick(v[i], 1'b0);
    end
  endtask

  // releases reset on a falling edge so the next rising edge is the first
  // post-reset edge, carrying bit b / align al
  task automatic release_reset(input logic b, input logic al);
    @(negedge clk);
    reset = 1'b1;
    in    = b;
    align = al;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset     = 1'b0;
    in        = 1'b0;
    align     = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out",       out,              8'h00);
    chk("rst_valid",     {7'd0, out_valid}, 8'h00);
    chk("rst_overrun",   {7'd0, overrun},   8'h00);
    chk("rst_state",     {7'd0, dbg_state}, {7'd0, SKIP});
    chk("rst_bitcnt",    {5'd0, dbg_bitcnt}, 8'h00);

    // skip edge discards a 1
    release_reset(1'b1, 1'b0);
    chk("skip_state",    {7'd0, dbg_state}, {7'd0, RUN});
    chk("skip_bitcnt",   {5'd0, dbg_bitcnt}, 8'h00);
    chk("skip_valid",    {7'd0, out_valid}, 8'h00);

    // loopback A5 twice, ready high
    send(8'hA5, 0, 6);
    chk("a5_partial_valid", {7'd0, out_valid}, 8'h00);
    send(8'hA5, 7, 7);
    chk("a5_out",        out,               8'hA5);
    chk("a5_valid",      {7'd0, out_valid}, 8'h01);
    send(8'hA5, 0, 0);
    chk("a5_drain",      {7'd0, out_valid}, 8'h00);
    send(8'hA5, 1, 7);
    chk("a5_out2",       out,               8'hA5);
    chk("a5_valid2",     {7'd0, out_valid}, 8'h01);

    // 3C then C3; accept and completion at the same edge
    send(8'h3C, 0, 7);
    chk("3c_out",        out,               8'h3C);
    chk("3c_valid",      {7'd0, out_valid}, 8'h01);
    out_ready = 1'b0;
    send(8'hC3, 0, 6);
    chk("3c_hold_out",   out,               8'h3C);
    chk("3c_hold_valid", {7'd0, out_valid}, 8'h01);
    out_ready = 1'b1;
    send(8'hC3, 7, 7);
    chk("c3_out",        out,               8'hC3);
    chk("c3_valid",      {7'd0, out_valid}, 8'h01);
    chk("c3_overrun",    {7'd0, overrun},   8'h00);

    // two completions without ready: 11 kept, 22 dropped
    send(8'h11, 0, 0);
    chk("11_drain",      {7'd0, out_valid}, 8'h00);
    out_ready = 1'b0;
    send(8'h11, 1, 7);
    chk("11_out",        out,               8'h11);
    chk("11_overrun",    {7'd0, overrun},   8'h00);
    send(8'h22, 0, 7);
    chk("22_drop_out",   out,               8'h11);
    chk("22_drop_valid", {7'd0, out_valid}, 8'h01);
    chk("22_overrun",    {7'd0, overrun},   {7'd0, EXP_OVR});

    // align after four bits of a byte, then 5A
    send(8'h33, 0, 3);
    chk("pre_align_ovr", {7'd0, overrun},   {7'd0, EXP_OVR});
    out_ready = 1'b1;
    tick(1'b0, 1'b1);  // bit 0 of 5A
    chk("align_bitcnt",  {5'd0, dbg_bitcnt}, 8'h01);
    chk("align_out",     out,               8'h11);
    chk("align_valid",   {7'd0, out_valid}, 8'h00);
    chk("align_ovr",     {7'd0, overrun},   8'h00);
    send(8'h5A, 1, 6);
    chk("5a_partial",    {7'd0, out_valid}, 8'h00);
    send(8'h5A, 7, 7);
    chk("5a_out",        out,               8'h5A);
    chk("5a_valid",      {7'd0, out_valid}, 8'h01);

    // reset at bit 3 with a held byte
    out_ready = 1'b0;
    send(8'h77, 0, 2);
    chk("pre_rst_valid", {7'd0, out_valid}, 8'h01);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_out",   out,               8'h00);
    chk("mid_rst_valid", {7'd0, out_valid}, 8'h00);
    chk("mid_rst_ovr",   {7'd0, overrun},   8'h00);
    chk("mid_rst_state", {7'd0, dbg_state}, {7'd0, SKIP});
    chk("mid_rst_bitcnt", {5'd0, dbg_bitcnt}, 8'h00);
    out_ready = 1'b1;
    release_reset(1'b1, 1'b0);
    chk("rst2_skip_valid", {7'd0, out_valid}, 8'h00);
    send(8'hF0, 0, 7);
    chk("f0_out",        out,               8'hF0);
    chk("f0_valid",      {7'd0, out_valid}, 8'h01);

    // align on the skip edge takes priority
    #2;
    reset = 1'b0;
    #1;
    release_reset(1'b0, 1'b1);  // bit 0 of 96
    chk("skip_align_state",  {7'd0, dbg_state}, {7'd0, RUN});
    chk("skip_align_bitcnt", {5'd0, dbg_bitcnt}, 8'h01);
    send(8'h96, 1, 7);
    chk("96_out",        out,               8'h96);
    chk("96_valid",      {7'd0, out_valid}, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_deserializer

// File: doc/deserializer.md
DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port in, input, 1, serial data, LSB first, one bit per clk.
REQ-004 SHALL have port align, input, 1, framing restart; the bit on in in the same cycle becomes bit 0.
REQ-005 SHALL have port out, output, 8, assembled byte holding register.
REQ-006 SHALL have port out_valid, output, 1, out holds an unconsumed byte.
REQ-007 SHALL have port out_ready, input, 1, consumer accepts out when out_valid && out_ready at a clk edge.
REQ-008 SHALL have port overrun, output, 1, sticky flag: a completed byte was dropped.

Function
REQ-009 SHALL implement states SKIP, RUN; reset enters SKIP.
REQ-010 SKIP SHALL discard exactly one bit (the serializer's dead cycle after reset), then go to RUN with bit counter 0.
REQ-011 RUN SHALL store in into shift[bitcnt] each edge; bitcnt increments 0..7 and wraps 7->0 with no gap cycle.
REQ-012 At the edge sampling bit 7, out SHALL load {in, shift[6:0]} and out_valid SHALL be 1 after that edge (byte visible 8 edges after bit 0 sampled).
REQ-013 Handshake: out_valid SHALL clear at an edge with out_ready=1 unless a new byte completes at that same edge.
REQ-014 Simultaneous accept and completion SHALL load the new byte, keep out_valid=1, no overrun.
REQ-015 Completion while out_valid=1 and out_ready=0 SHALL keep the old out unchanged and drop the new byte.
REQ-016 align=1 (either state) SHALL set state RUN, store in as bit 0, set bitcnt to 1, and discard the partial byte; out and out_valid SHALL be unaffected.
REQ-017 align=1 during the SKIP cycle SHALL take priority over the skip.
REQ-018 out SHALL be stable whenever out_valid=1 and no load occurs.

Reset
REQ-019 reset low SHALL immediately force out=8'h00, out_valid=0, overrun=0, shift=0, bitcnt=0, state SKIP.
REQ-020 Reset mid-byte SHALL lose the partial byte and any unconsumed held byte.
REQ-021 First edge after reset deassertion SHALL be the SKIP edge.

Configuration
REQ-022 Macro DESER_OVERRUN_EN defined: overrun SHALL set on any REQ-015 drop and stay 1 until reset or align=1.
REQ-023 Macro DESER_OVERRUN_EN undefined: overrun SHALL be tied 0; drop behaviour of REQ-015 is unchanged.

Structure
REQ-024 Shared package deser_pkg SHALL hold DATA_W=8, BITCNT_W=3 and the state enum {SKIP, RUN}.
REQ-025 Bit-assembly shift register and counter SHALL be one sub-module deser_shift (in, align, bit index, byte_done, byte); handshake, state machine and overrun stay in deserializer.

Verification
REQ-026 Loopback: serializer with in=8'hA5 drives in -> out=8'hA5, out_valid every 8 clk after first byte, out_ready=1 throughout.
REQ-027 Back-to-back bytes 8'h3C then 8'hC3 with out_ready=1 -> out 8'h3C then 8'hC3, out_valid held 1 across the completion edge (REQ-014).
REQ-028 out_ready=0 over two completions (8'h11, 8'h22) -> out stays 8'h11, overrun=1 with macro, 0 without.
REQ-029 align pulse at bit 4 of a byte, then bits of 8'h5A -> partial discarded, out=8'h5A 8 edges after align, overrun cleared.
REQ-030 reset asserted at bit 3 with out_valid=1 -> all outputs 0 immediately; first post-reset bit discarded, next 8 bits of 8'hF0 give out=8'hF0.
